// File: rtl/fetch_pkg.sv
// Shared types and defaults for the IF stage of the 20-bit core.
package fetch_pkg;

  localparam int PC_W_DEF    = 15;
  localparam int INSTR_W_DEF = 20;
  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = 20'h00000;

  typedef enum logic [1:0] {
    S_RST,
    S_REQ,
    S_DROP,
    S_HELD
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding register used when a fetch completes under a decode stall.
module fetch_skid_buf #(
  parameter int PC_W    = 15,
  parameter int INSTR_W = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic               full_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o
);

  logic               full_q, full_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_q, pc_d;

  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (clear_i) full_d = 1'b0;
    // A load in the same cycle as a clear wins: the entry is refilled.
    if (load_i) begin
      full_d  = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q  <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign full_o  = full_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns PCF, fetches over a req/ready imem port and drives the IF/ID register.
// Optional macro FETCH_PERF_EN adds FetchCnt/BubbleCnt saturating counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                 PC_W      = PC_W_DEF,
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               StallD,
  input  logic               FlushD,
  input  logic               PCSrcE,
  input  logic [PC_W-1:0]    PCTargetE,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] InstrD,
  output logic [PC_W-1:0]    PCD,
  output logic [PC_W-1:0]    PCPlus1D,
  output logic               ValidD,
`ifdef FETCH_PERF_EN
  output logic [31:0]        FetchCnt,
  output logic [31:0]        BubbleCnt,
`endif
  output fetch_state_t       dbg_state
);

  // imem handshake: a transfer completes in the cycle imem_req && imem_ready;
  // until then imem_req and imem_addr are held stable and imem_rdata is ignored.
  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pcf_q, pcf_d;
  logic [PC_W-1:0]    tgt_q, tgt_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pcd_q, pcd_d;
  logic [PC_W-1:0]    pcp1_q, pcp1_d;
  logic               valid_q, valid_d;

  logic               fire;
  logic               skid_load, skid_clear, skid_full;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;
  logic               load_en;
  logic [INSTR_W-1:0] load_instr;
  logic [PC_W-1:0]    load_pc;

  fetch_skid_buf #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .instr_i (imem_rdata),
    .pc_i    (pcf_q),
    .full_o  (skid_full),
    .instr_o (skid_instr),
    .pc_o    (skid_pc)
  );

  // Reset abandons an outstanding request in the same cycle.
  assign imem_req  = ((state_q == S_REQ) || (state_q == S_DROP)) && !reset;
  assign imem_addr = pcf_q;
  assign fire      = imem_req && imem_ready;

  always_comb begin
    state_d    = state_q;
    pcf_d      = pcf_q;
    tgt_d      = tgt_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    load_en    = 1'b0;
    load_instr = imem_rdata;
    load_pc    = pcf_q;
    case (state_q)
      S_RST: state_d = S_REQ;
      S_REQ: begin
        if (fire) begin
          if (PCSrcE) begin
            pcf_d = PCTargetE;
          end else if (StallD) begin
            skid_load = 1'b1;
            pcf_d     = pcf_q + PC_ONE;
            state_d   = S_HELD;
          end else begin
            load_en = 1'b1;
            pcf_d   = pcf_q + PC_ONE;
          end
        end else if (PCSrcE) begin
          tgt_d   = PCTargetE;
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (PCSrcE) tgt_d = PCTargetE;
        if (fire) begin
          pcf_d   = PCSrcE ? PCTargetE : tgt_q;
          state_d = S_REQ;
        end
      end
      S_HELD: begin
        // A redirect means the parked word is wrong-path, so it beats release.
        if (PCSrcE) begin
          skid_clear = 1'b1;
          pcf_d      = PCTargetE;
          state_d    = S_REQ;
        end else if (!StallD) begin
          load_en    = skid_full;
          load_instr = skid_instr;
          load_pc    = skid_pc;
          skid_clear = 1'b1;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pcp1_d  = pcp1_q;
    valid_d = valid_q;
    if (FlushD) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (StallD) begin
      valid_d = valid_q;
    end else if (load_en) begin
      instr_d = load_instr;
      pcd_d   = load_pc;
      pcp1_d  = load_pc + PC_ONE;
      valid_d = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST;
      pcf_q   <= RESET_PC;
      tgt_q   <= '0;
      instr_q <= NOP_INSTR;
      pcd_q   <= '0;
      pcp1_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pcf_q   <= pcf_d;
      tgt_q   <= tgt_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pcp1_q  <= pcp1_d;
      valid_q <= valid_d;
    end
  end

  assign InstrD    = instr_q;
  assign PCD       = pcd_q;
  assign PCPlus1D  = pcp1_q;
  assign ValidD    = valid_q;
  assign dbg_state = state_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (load_en && !FlushD && !StallD && (fetch_cnt_q != '1))
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (!valid_d && (bubble_cnt_q != '1))
      bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign FetchCnt  = fetch_cnt_q;
  assign BubbleCnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall, ready-low redirect, wrap, flush and reset cases.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int PC_W    = 15;
  localparam int INSTR_W = 20;
  localparam logic [INSTR_W-1:0] NOP = 20'h00000;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic               StallD, FlushD, PCSrcE;
  logic [PC_W-1:0]    PCTargetE;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] InstrD;
  logic [PC_W-1:0]    PCD, PCPlus1D;
  logic               ValidD;
  fetch_state_t       dbg_state;
`ifdef FETCH_PERF_EN
  logic [31:0]        fetch_cnt, bubble_cnt;
`endif

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus1D   (PCPlus1D),
    .ValidD     (ValidD),
`ifdef FETCH_PERF_EN
    .FetchCnt   (fetch_cnt),
    .BubbleCnt  (bubble_cnt),
`endif
    .dbg_state  (dbg_state)
  );

  // Instruction memory model: word content derived from the address.
  function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] a);
    return {5'h15, a ^ 15'h1234};
  endfunction

  assign imem_rdata = imem_ready ? mem_word(imem_addr) : '0;

  // scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [PC_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [PC_W-1:0] pc;
    reset      = 1'b1;
    StallD     = 1'b0;
    FlushD     = 1'b0;
    PCSrcE     = 1'b0;
    PCTargetE  = '0;
    imem_ready = 1'b1;
    step();
    step();
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_valid", 32'(ValidD), 32'd0);
    check("rst_instr", 32'(InstrD), 32'(NOP));
    check("rst_pcd",   32'(PCD), 32'd0);
    check("rst_pcp1",  32'(PCPlus1D), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_RST));

    reset = 1'b0;
    step();
    check("srst_valid", 32'(ValidD), 32'd0);
    check("first_req",  32'(imem_req), 32'd1);
    check("first_addr", 32'(imem_addr), 32'd0);

    // streaming at one instruction per cycle
    for (int k = 0; k < 5; k++) exp_q.push_back(PC_W'(k));
    for (int k = 0; k < 5; k++) begin
      step();
      pc = exp_q.pop_front();
      check("stream_pcd",   32'(PCD), 32'(pc));
      check("stream_instr", 32'(InstrD), 32'(mem_word(pc)));
      check("stream_valid", 32'(ValidD), 32'd1);
      check("stream_pcp1",  32'(PCPlus1D), 32'(pc + 15'd1));
    end
    check("stream_addr", 32'(imem_addr), 32'd5);

    // three-cycle decode stall
    StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pcd",   32'(PCD), 32'd4);
      check("stall_instr", 32'(InstrD), 32'(mem_word(15'd4)));
      check("stall_valid", 32'(ValidD), 32'd1);
      check("stall_req",   32'(imem_req), 32'd0);
      check("stall_state", 32'(dbg_state), 32'(S_HELD));
    end
    StallD = 1'b0;
    step();
    check("rel_pcd",   32'(PCD), 32'd5);
    check("rel_instr", 32'(InstrD), 32'(mem_word(15'd5)));
    check("rel_valid", 32'(ValidD), 32'd1);
    check("rel_addr",  32'(imem_addr), 32'd6);
    step();
    check("rel2_pcd",  32'(PCD), 32'd6);
    check("rel2_addr", 32'(imem_addr), 32'd7);

    // imem stalls four cycles while a redirect arrives
    imem_ready = 1'b0;
    step();
    check("wait_valid", 32'(ValidD), 32'd0);
    check("wait_req",   32'(imem_req), 32'd1);
    check("wait_addr",  32'(imem_addr), 32'd7);
    PCSrcE    = 1'b1;
    PCTargetE = 15'h0100;
    step();
    check("drop_state", 32'(dbg_state), 32'(S_DROP));
    check("drop_addr",  32'(imem_addr), 32'd7);
    PCSrcE    = 1'b0;
    PCTargetE = 15'h0000;
    for (int i = 0; i < 2; i++) begin
      step();
      check("drop_hold_addr", 32'(imem_addr), 32'd7);
      check("drop_hold_req",  32'(imem_req), 32'd1);
    end
    imem_ready = 1'b1;
    step();
    check("redir_addr",  32'(imem_addr), 32'h100);
    check("redir_valid", 32'(ValidD), 32'd0);
    check("redir_state", 32'(dbg_state), 32'(S_REQ));
    step();
    check("redir_pcd",   32'(PCD), 32'h100);
    check("redir_instr", 32'(InstrD), 32'(mem_word(15'h100)));
    check("redir_vld",   32'(ValidD), 32'd1);

    // redirect on a completing fetch, landing on the wrap point
    PCSrcE    = 1'b1;
    PCTargetE = 15'h7FFF;
    step();
    check("cmp_redir_valid", 32'(ValidD), 32'd0);
    check("cmp_redir_addr",  32'(imem_addr), 32'h7FFF);
    PCSrcE = 1'b0;
    step();
    check("wrap_pcd",  32'(PCD), 32'h7FFF);
    check("wrap_pcp1", 32'(PCPlus1D), 32'd0);
    check("wrap_addr", 32'(imem_addr), 32'd0);
    step();
    check("wrap_next_pcd",   32'(PCD), 32'd0);
    check("wrap_next_instr", 32'(InstrD), 32'(mem_word(15'd0)));

    // stall and flush together
    StallD = 1'b1;
    FlushD = 1'b1;
    step();
    check("flush_instr", 32'(InstrD), 32'(NOP));
    check("flush_valid", 32'(ValidD), 32'd0);
    check("flush_pcd",   32'(PCD), 32'd0);
    StallD = 1'b0;
    FlushD = 1'b0;
    step();
    check("post_flush_pcd",   32'(PCD), 32'd1);
    check("post_flush_instr", 32'(InstrD), 32'(mem_word(15'd1)));
    check("post_flush_valid", 32'(ValidD), 32'd1);
    check("post_flush_addr",  32'(imem_addr), 32'd2);

    // reset while waiting in S_DROP
    imem_ready = 1'b0;
    PCSrcE     = 1'b1;
    PCTargetE  = 15'h0055;
    step();
    check("pre_rst_state", 32'(dbg_state), 32'(S_DROP));
    check("pre_rst_addr",  32'(imem_addr), 32'd2);
    PCSrcE = 1'b0;
    reset  = 1'b1;
    #1;
    check("rst_abandon_req", 32'(imem_req), 32'd0);
    step();
    check("drop_rst_req",   32'(imem_req), 32'd0);
    check("drop_rst_addr",  32'(imem_addr), 32'd0);
    check("drop_rst_valid", 32'(ValidD), 32'd0);
    check("drop_rst_pcd",   32'(PCD), 32'd0);
    check("drop_rst_state", 32'(dbg_state), 32'(S_RST));
    reset      = 1'b0;
    imem_ready = 1'b1;
    step();
    check("restart_req",  32'(imem_req), 32'd1);
    check("restart_addr", 32'(imem_addr), 32'd0);
    step();
    check("restart_pcd",   32'(PCD), 32'd0);
    check("restart_valid", 32'(ValidD), 32'd1);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
